// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller: exception
// codes, CP0 register addresses, bus widths and the MTC0 forwarding helper.
package exc_ctrl_pkg;

    localparam int HARDINT_W = 6;
    localparam int DATABUS_W = 32;
    localparam int ADDRBUS_W = 32;

    localparam logic [31:0] EXCT_NONE = 32'h0000_0000;
    localparam logic [31:0] EXCT_INT  = 32'h0000_0001;
    localparam logic [31:0] EXCT_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXCT_ADES = 32'h0000_0005;
    localparam logic [31:0] EXCT_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXCT_BP   = 32'h0000_0009;
    localparam logic [31:0] EXCT_RI   = 32'h0000_000A;
    localparam logic [31:0] EXCT_OV   = 32'h0000_000C;
    localparam logic [31:0] EXCT_ERET = 32'h0000_000E;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // One arbitration result: the code issued to CP0 and its faulting address.
    typedef struct packed {
        logic [DATABUS_W-1:0] code;
        logic [ADDRBUS_W-1:0] badvaddr;
    } exc_sel_t;

    // A CP0 register as seen this cycle: an MTC0 in MEM to the same register
    // has not reached CP0 yet, so its data takes precedence.
    function automatic logic [DATABUS_W-1:0] cp0_fwd(
        input logic                 we,
        input logic [4:0]           waddr,
        input logic [4:0]           reg_addr,
        input logic [DATABUS_W-1:0] wdata,
        input logic [DATABUS_W-1:0] cur
    );
        return (we && (waddr == reg_addr)) ? wdata : cur;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-stage flop synchroniser for a vector of asynchronous interrupt lines.
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p [STAGES];

    // Shift every line through STAGES flops; all stages clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_p[i] <= '0;
        end else begin
            sync_p[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter and pipeline redirect unit. Picks one
// exception per instruction, reports it to CP0 and holds the pipeline
// flush/redirect for FLUSH_CYCLES cycles after the detect cycle.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HARDINT_W-1:0] hw_int,
    output logic [HARDINT_W-1:0] intr,
    input  logic                 mem_valid,
    input  logic [ADDRBUS_W-1:0] mem_pc,
    input  logic [ADDRBUS_W-1:0] mem_addr,
    input  logic                 if_adel,
    input  logic                 id_ri,
    input  logic                 id_sys,
    input  logic                 id_bp,
    input  logic                 ex_ov,
    input  logic                 mem_adel,
    input  logic                 mem_ades,
    input  logic                 id_eret,
    input  logic                 cp0_we,
    input  logic [4:0]           cp0_waddr,
    input  logic [DATABUS_W-1:0] cp0_wdata,
    input  logic [DATABUS_W-1:0] cp0_status,
    input  logic [DATABUS_W-1:0] cp0_cause,
    input  logic [DATABUS_W-1:0] cp0_epc,
    output logic [DATABUS_W-1:0] exctype,
    output logic [ADDRBUS_W-1:0] badvaddr,
    output logic                 flush,
    output logic [ADDRBUS_W-1:0] new_pc,
    output logic                 busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    logic [0:0]           state;
    logic [3:0]           cnt;
    logic [ADDRBUS_W-1:0] npc_q;

    logic [DATABUS_W-1:0] status_eff;
    logic [DATABUS_W-1:0] cause_eff;
    logic [DATABUS_W-1:0] epc_eff;
    logic                 int_pending;
    exc_sel_t             sel;
    logic                 detect;
    logic                 in_flush;
    logic [ADDRBUS_W-1:0] detect_pc;
    logic                 unused_cp0_bits;

    int_sync #(
        .WIDTH  (HARDINT_W),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (intr)
    );

    assign status_eff = cp0_fwd(cp0_we, cp0_waddr, CP0_STATUS, cp0_wdata, cp0_status);
    assign cause_eff  = cp0_fwd(cp0_we, cp0_waddr, CP0_CAUSE,  cp0_wdata, cp0_cause);
    assign epc_eff    = cp0_fwd(cp0_we, cp0_waddr, CP0_EPC,    cp0_wdata, cp0_epc);

    // Only IM/IP, IE and EXL take part in interrupt qualification.
    assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                               cause_eff[31:16], cause_eff[7:0]};

    // Interrupt needs a pending-and-enabled line, IE set and EXL clear.
    assign int_pending = (|(cause_eff[15:8] & status_eff[15:8]))
                         && status_eff[0] && !status_eff[1];

    // Fixed-priority pick; an address error also selects its faulting address.
    always_comb begin
        sel.code     = EXCT_NONE;
        sel.badvaddr = '0;
        if (int_pending) begin
            sel.code = EXCT_INT;
        end else if (if_adel) begin
            sel.code     = EXCT_ADEL;
            sel.badvaddr = mem_pc;
        end else if (id_ri) begin
            sel.code = EXCT_RI;
        end else if (id_sys) begin
            sel.code = EXCT_SYS;
        end else if (id_bp) begin
            sel.code = EXCT_BP;
        end else if (ex_ov) begin
            sel.code = EXCT_OV;
        end else if (mem_adel) begin
            sel.code     = EXCT_ADEL;
            sel.badvaddr = mem_addr;
        end else if (mem_ades) begin
            sel.code     = EXCT_ADES;
            sel.badvaddr = mem_addr;
        end else if (id_eret) begin
            sel.code = EXCT_ERET;
        end
    end

    // Outputs are forced quiet while reset is held, even with flags present.
    assign detect    = !rst && (state == ST_IDLE) && mem_valid && (sel.code != EXCT_NONE);
    assign in_flush  = !rst && (state == ST_FLUSH);
    assign detect_pc = (sel.code == EXCT_ERET) ? epc_eff : EXC_VECTOR;

    assign exctype  = detect ? sel.code : EXCT_NONE;
    assign badvaddr = detect ? sel.badvaddr : '0;
    assign flush    = detect || in_flush;
    assign busy     = in_flush;
    assign new_pc   = detect ? detect_pc : (in_flush ? npc_q : '0);

    // IDLE -> FLUSH on detect, holding the redirect PC; count down back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            npc_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (detect) begin
                        state <= ST_FLUSH;
                        cnt   <= FLUSH_INIT;
                        npc_q <= detect_pc;
                    end
                end
                default: begin
                    if (cnt <= 4'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: per-cycle expectations are queued as the
// stimulus is applied and compared when the outputs are sampled.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic [5:0]  intr;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic        if_adel, id_ri, id_sys, id_bp, ex_ov, mem_adel, mem_ades, id_eret;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata, cp0_status, cp0_cause, cp0_epc;
    logic [31:0] exctype, badvaddr, new_pc;
    logic        flush, busy;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct {
        logic [31:0] exctype;
        logic [31:0] badvaddr;
        logic [31:0] new_pc;
        logic        flush;
        logic        busy;
        logic [5:0]  intr;
    } exp_t;

    exp_t   sbq[$];
    string  tagq[$];
    int     checks = 0;
    int     errors = 0;
    logic [5:0] intr_exp;

    exc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .hw_int     (hw_int),
        .intr       (intr),
        .mem_valid  (mem_valid),
        .mem_pc     (mem_pc),
        .mem_addr   (mem_addr),
        .if_adel    (if_adel),
        .id_ri      (id_ri),
        .id_sys     (id_sys),
        .id_bp      (id_bp),
        .ex_ov      (ex_ov),
        .mem_adel   (mem_adel),
        .mem_ades   (mem_ades),
        .id_eret    (id_eret),
        .cp0_we     (cp0_we),
        .cp0_waddr  (cp0_waddr),
        .cp0_wdata  (cp0_wdata),
        .cp0_status (cp0_status),
        .cp0_cause  (cp0_cause),
        .cp0_epc    (cp0_epc),
        .exctype    (exctype),
        .badvaddr   (badvaddr),
        .flush      (flush),
        .new_pc     (new_pc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [31:0] et, input logic [31:0] ba,
                              input logic [31:0] np, input logic fl, input logic bz);
        exp_t e;
        e.exctype  = et;
        e.badvaddr = ba;
        e.new_pc   = np;
        e.flush    = fl;
        e.busy     = bz;
        e.intr     = intr_exp;
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        exp_t  e;
        string t;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            t = tagq.pop_front();
            chk({t, ".exctype"},  exctype,  e.exctype);
            chk({t, ".badvaddr"}, badvaddr, e.badvaddr);
            chk({t, ".new_pc"},   new_pc,   e.new_pc);
            chk({t, ".flush"},    32'(flush), 32'(e.flush));
            chk({t, ".busy"},     32'(busy),  32'(e.busy));
            chk({t, ".intr"},     32'(intr),  32'(e.intr));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        mem_valid = 1'b0; if_adel = 1'b0; id_ri = 1'b0; id_sys = 1'b0; id_bp = 1'b0;
        ex_ov = 1'b0; mem_adel = 1'b0; mem_ades = 1'b0; id_eret = 1'b0;
        cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'h0;
        cp0_status = 32'h0; cp0_cause = 32'h0;
    endtask

    task automatic detect_then_flush(input string tag, input logic [31:0] et,
                                     input logic [31:0] ba, input logic [31:0] np);
        expect_cyc({tag, "_det"}, et, ba, np, 1'b1, 1'b0);
        tick();
        clear_flags();
        expect_cyc({tag, "_fl"}, 32'h0, 32'h0, np, 1'b1, 1'b1);
        tick();
        expect_cyc({tag, "_idle"}, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; hw_int = 6'b0; mem_pc = 32'h0; mem_addr = 32'h0; cp0_epc = 32'h0;
        intr_exp = 6'b0;
        clear_flags();
        @(posedge clk);
        #1;

        // Outputs stay quiet while reset holds, even with a flagged instruction.
        mem_valid = 1'b1; ex_ov = 1'b1;
        expect_cyc("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // Release reset and raise one interrupt line; two edges to reach intr.
        clear_flags();
        rst = 1'b0;
        hw_int = 6'b000100;
        expect_cyc("sync0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        expect_cyc("sync1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        intr_exp = 6'b000100;
        expect_cyc("sync2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // Enabled interrupt.
        cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
        mem_valid = 1'b1; mem_pc = 32'h8000_0040;
        detect_then_flush("int", 32'h1, 32'h0, VEC);

        // Interrupt masked by EXL, by IM mismatch, and by an MTC0 clearing IE.
        cp0_status = 32'h0000_0403; cp0_cause = 32'h0000_0400; mem_valid = 1'b1;
        expect_cyc("int_exl", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        cp0_status = 32'h0000_0801;
        expect_cyc("int_im", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        cp0_status = 32'h0000_0401;
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0400;
        expect_cyc("int_mtc0_ie", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // Cause pending bit arrives through MTC0 forwarding.
        cp0_cause = 32'h0; cp0_waddr = 5'd13; cp0_wdata = 32'h0000_0400;
        detect_then_flush("int_fwd", 32'h1, 32'h0, VEC);

        // No exception when MEM is empty.
        ex_ov = 1'b1; mem_valid = 1'b0;
        expect_cyc("no_valid", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        clear_flags();

        // Priority cases.
        mem_valid = 1'b1; mem_adel = 1'b1; mem_ades = 1'b1; id_sys = 1'b1; mem_addr = 32'h1003;
        detect_then_flush("sys", 32'h8, 32'h0, VEC);
        mem_valid = 1'b1; if_adel = 1'b1; id_ri = 1'b1; mem_pc = 32'h8000_0002;
        detect_then_flush("if_adel", 32'h4, 32'h8000_0002, VEC);
        mem_valid = 1'b1; mem_adel = 1'b1; mem_ades = 1'b1; id_eret = 1'b1;
        detect_then_flush("mem_adel", 32'h4, 32'h1003, VEC);
        mem_valid = 1'b1; mem_ades = 1'b1; id_eret = 1'b1;
        detect_then_flush("ades", 32'h5, 32'h1003, VEC);
        mem_valid = 1'b1; id_ri = 1'b1; id_bp = 1'b1;
        detect_then_flush("ri", 32'hA, 32'h0, VEC);
        mem_valid = 1'b1; id_bp = 1'b1; ex_ov = 1'b1;
        detect_then_flush("bp", 32'h9, 32'h0, VEC);

        // Interrupt beats ERET.
        cp0_epc = 32'h8000_1000;
        mem_valid = 1'b1; id_eret = 1'b1; cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
        detect_then_flush("int_eret", 32'h1, 32'h0, VEC);

        // ERET uses the in-flight EPC write; the held target survives its removal.
        mem_valid = 1'b1; id_eret = 1'b1;
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h8000_2000;
        detect_then_flush("eret", 32'hE, 32'h0, 32'h8000_2000);

        // Back-to-back overflow: second one falls into FLUSH and is dropped.
        mem_valid = 1'b1; ex_ov = 1'b1;
        expect_cyc("ov1", 32'hC, 32'h0, VEC, 1'b1, 1'b0);
        tick();
        expect_cyc("ov2", 32'h0, 32'h0, VEC, 1'b1, 1'b1);
        tick();
        clear_flags();
        expect_cyc("ov_idle", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // Reset asserted mid-FLUSH drops flush without waiting for a clock.
        mem_valid = 1'b1; ex_ov = 1'b1;
        expect_cyc("ov3", 32'hC, 32'h0, VEC, 1'b1, 1'b0);
        tick();
        clear_flags();
        chk("midfl.flush", 32'(flush), 32'h1);
        chk("midfl.busy",  32'(busy),  32'h1);
        rst = 1'b1;
        #1;
        chk("rstfl.flush",  32'(flush), 32'h0);
        chk("rstfl.busy",   32'(busy),  32'h0);
        chk("rstfl.new_pc", new_pc,     32'h0);
        chk("rstfl.intr",   32'(intr),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        intr_exp = 6'b0;
        expect_cyc("post_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        chk("sb_drain", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception arbiter and pipeline redirect unit; the initiator side of the CP0 exception interface.
- Collects per-instruction exception flags and synchronises hardware interrupt lines. Reads CP0 status/cause/epc, forwarding any in-flight MTC0.
- Issues exactly one exctype code and badvaddr to CP0 per exception. Drives pipeline flush and redirect PC for a fixed number of cycles.

Parameters:
- EXC_VECTOR, 32'hBFC00380, handler entry PC for every exception except ERET.
- FLUSH_CYCLES, 1, cycles the FLUSH state holds flush after the detect cycle (range 1..15).
- SYNC_STAGES, 2, flip-flop stages on each hw_int bit (range 2..4).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- hw_int  in  6  raw external interrupt lines
- intr  out  6  synchronised interrupts, fed to CP0 cause[15:10]
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  32  PC of MEM instruction
- mem_addr  in  32  data address of MEM load/store
- if_adel  in  1  fetch address error
- id_ri  in  1  reserved instruction
- id_sys  in  1  syscall
- id_bp  in  1  break
- ex_ov  in  1  arithmetic overflow
- mem_adel  in  1  load address error
- mem_ades  in  1  store address error
- id_eret  in  1  eret
- cp0_we  in  1  MEM-stage MTC0 write enable
- cp0_waddr  in  5  MTC0 target register
- cp0_wdata  in  32  MTC0 data
- cp0_status  in  32  CP0 status
- cp0_cause  in  32  CP0 cause
- cp0_epc  in  32  CP0 epc
- exctype  out  32  exception code to CP0
- badvaddr  out  32  faulting address to CP0
- flush  out  1  flush IF..MEM pipeline registers
- new_pc  out  32  redirect target, valid while flush=1
- busy  out  1  high in FLUSH state

Behaviour:
- Reset values: intr=0, all sync stages=0, state=IDLE, stored new_pc=0. Combinationally in reset: exctype=EXCT_NONE, badvaddr=0, flush=0, new_pc=0, busy=0.
- Interrupt sync:
  - Each hw_int bit passes through SYNC_STAGES flops.
  - intr is the last stage; latency is SYNC_STAGES cycles.
- Forwarding:
  - If cp0_we and cp0_waddr is 12, 13 or 14, the effective status, cause or epc is cp0_wdata.
  - Otherwise the effective value is the cp0_* input.
- Interrupt pending: (cause_eff[15:8] & status_eff[15:8]) != 0, AND status_eff[0]=1, AND status_eff[1]=0.
- Detect: only in IDLE with mem_valid=1. Priority, highest first, with badvaddr shown where driven:
  1. INT
  2. if_adel as ADEL, badvaddr=mem_pc
  3. RI
  4. SYS
  5. BP
  6. OV
  7. mem_adel as ADEL, badvaddr=mem_addr
  8. ADES, badvaddr=mem_addr
  9. ERET
- badvaddr is 0 when no address error is selected.
- Detect cycle outputs (combinational, same cycle):
  - exctype = selected code.
  - flush=1.
  - new_pc = epc_eff for ERET, otherwise EXC_VECTOR.
  - new_pc is also registered. Next state is FLUSH with counter=FLUSH_CYCLES.
- FLUSH state:
  - exctype=EXCT_NONE; all flags and interrupts are ignored.
  - flush=1, new_pc = stored value, busy=1.
  - Counter decrements each cycle; at 1, next state is IDLE.
- IDLE with no exception, or mem_valid=0: exctype=EXCT_NONE, flush=0, new_pc=0.
- Simultaneous events:
  - A single code is issued per detect, chosen by priority.
  - An interrupt together with ERET issues INT.
  - MTC0 writing status IE=0 in the same cycle masks the interrupt.
- Reset mid-FLUSH: immediate return to IDLE; flush drops asynchronously.
- Codes (32-bit, shared): NONE=0, INT=1, ADEL=4, ADES=5, SYS=8, BP=9, RI=0xA, OV=0xC, ERET=0xE.

Decomposition:
- Shared defines:
  - EXCT_* codes.
  - CP0 register addresses: BADVADDR=8, STATUS=12, CAUSE=13, EPC=14.
  - HardInt width 6; DataBus and AddrBus widths 32.
- Sub-module int_sync: a parameterised multi-stage synchroniser, one instance for the 6-bit vector.

Test Plan:
1. Reset is released; hw_int=6'b000100 is asserted -> intr=6'b000100 exactly 2 cycles later.
2. status=32'h0000_0401, cause[10]=1, mem_valid=1, mem_pc=32'h8000_0040 -> one cycle with exctype=1, flush=1, new_pc=32'hBFC00380. Then one FLUSH cycle with busy=1, then IDLE.
3. mem_adel=1, mem_ades=1, id_sys=1, mem_addr=32'h1003 -> exctype=8, badvaddr=0.
4. if_adel=1, mem_pc=32'h8000_0002 -> exctype=4, badvaddr=32'h8000_0002.
5. id_eret=1, cp0_epc=32'h8000_1000, with MTC0 EPC=32'h8000_2000 in the same cycle -> exctype=0xE, new_pc=32'h8000_2000.
6. Two ex_ov pulses on consecutive cycles -> one exctype=0xC only, the second ignored during FLUSH. Assert rst during FLUSH -> flush=0 immediately.
